motor_cmd_rx: RTL and testbench



---
 rtl/motor_pkg.sv | 66 ++++++
 rtl/uart_rx_byte.sv | 120 ++++++++++++
 rtl/motor_cmd_rx.sv | 86 ++++++++
 tb/tb_motor_cmd_rx.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/motor_pkg.sv
// Shared definitions for the motor command path: ASCII command bytes,
// direction encoding used by the H-bridge controller, and the decoder.
package motor_pkg;

  localparam logic [7:0] CMD_F_UC = 8'h46;
  localparam logic [7:0] CMD_F_LC = 8'h66;
  localparam logic [7:0] CMD_B_UC = 8'h42;
  localparam logic [7:0] CMD_B_LC = 8'h62;
  localparam logic [7:0] CMD_L_UC = 8'h4C;
  localparam logic [7:0] CMD_L_LC = 8'h6C;
  localparam logic [7:0] CMD_R_UC = 8'h52;
  localparam logic [7:0] CMD_R_LC = 8'h72;
  localparam logic [7:0] CMD_S_UC = 8'h53;
  localparam logic [7:0] CMD_S_LC = 8'h73;

  typedef enum logic [2:0] {
    DIR_STOP     = 3'd0,
    DIR_FORWARD  = 3'd1,
    DIR_BACKWARD = 3'd2,
    DIR_LEFT     = 3'd3,
    DIR_RIGHT    = 3'd4
  } dir_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_IDLE
  } rx_state_e;

  typedef struct packed {
    logic valid;
    dir_e dir;
  } cmd_t;

  // Case-insensitive decode of a received byte into a direction.
  function automatic cmd_t decode_cmd(input logic [7:0] b);
    cmd_t c;
    c.valid = 1'b1;
    c.dir   = DIR_STOP;
    case (b)
      CMD_F_UC, CMD_F_LC: c.dir = DIR_FORWARD;
      CMD_B_UC, CMD_B_LC: c.dir = DIR_BACKWARD;
      CMD_L_UC, CMD_L_LC: c.dir = DIR_LEFT;
      CMD_R_UC, CMD_R_LC: c.dir = DIR_RIGHT;
      CMD_S_UC, CMD_S_LC: c.dir = DIR_STOP;
      default:            c.valid = 1'b0;
    endcase
    return c;
  endfunction

  // One-hot {F,B,L,R} drive request for a direction; STOP is all zero.
  function automatic logic [3:0] dir_to_fblr(input dir_e d);
    logic [3:0] v;
    case (d)
      DIR_FORWARD:  v = 4'b1000;
      DIR_BACKWARD: v = 4'b0100;
      DIR_LEFT:     v = 4'b0010;
      DIR_RIGHT:    v = 4'b0001;
      default:      v = 4'b0000;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-FF synchroniser, start-bit glitch rejection,
// centre sampling, and break handling (waits for line idle after a bad stop bit).
module uart_rx_byte
  import motor_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  logic            rx_meta;
  logic            rx_sync;
  rx_state_e       state_q, state_d;
  logic [CW-1:0]   clk_cnt_q, clk_cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            byte_valid_d;
  logic            frame_err_d;

  // Two-flop synchroniser for the asynchronous rx line (idles high).
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  // Receive FSM state, counters, shift register and result pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RX_IDLE;
      clk_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state_q    <= state_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      byte_valid <= byte_valid_d;
      frame_err  <= frame_err_d;
    end
  end

  // Next-state logic: half-bit to the start centre, then one bit period per sample.
  always_comb begin
    state_d      = state_q;
    clk_cnt_d    = clk_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (!rx_sync) begin
          state_d   = RX_START;
          clk_cnt_d = '0;
          bit_cnt_d = '0;
        end
      end
      RX_START: begin
        if (clk_cnt_q == HALF_LAST) begin
          clk_cnt_d = '0;
          state_d   = rx_sync ? RX_IDLE : RX_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          shift_d   = {rx_sync, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = RX_STOP;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          if (rx_sync) begin
            byte_valid_d = 1'b1;
            state_d      = RX_IDLE;
          end else begin
            frame_err_d  = 1'b1;
            state_d      = RX_WAIT_IDLE;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      RX_WAIT_IDLE: begin
        if (rx_sync) begin
          state_d = RX_IDLE;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign data = shift_q;

endmodule

// File: rtl/motor_cmd_rx.sv
// UART command receiver producing held one-hot F/B/L/R drive requests,
// with a watchdog that forces STOP when no valid command arrives in time.
module motor_cmd_rx
  import motor_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208,
  parameter int TIMEOUT_CLKS = 25000000
) (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic F,
  output logic B,
  output logic L,
  output logic R,
  output logic cmd_valid,
  output logic frame_err,
  output logic timeout
);

  localparam int WDW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CLKS - 1);

  logic [7:0]     rx_data;
  logic           rx_byte_valid;
  cmd_t           rx_cmd;
  logic           cmd_hit;
  logic           drive_on;
  logic [3:0]     fblr_d;
  logic           cmd_valid_d;
  logic           timeout_d;
  logic [WDW-1:0] wd_cnt_q, wd_cnt_d;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data      (rx_data),
    .byte_valid(rx_byte_valid),
    .frame_err (frame_err)
  );

  assign rx_cmd   = decode_cmd(rx_data);
  assign cmd_hit  = rx_byte_valid & rx_cmd.valid;
  assign drive_on = F | B | L | R;

  // A recognised command takes priority over watchdog expiry on the same cycle;
  // with outputs already at STOP the counter parks at its last value.
  always_comb begin
    fblr_d      = {F, B, L, R};
    cmd_valid_d = 1'b0;
    timeout_d   = 1'b0;
    wd_cnt_d    = wd_cnt_q;
    if (cmd_hit) begin
      fblr_d      = dir_to_fblr(rx_cmd.dir);
      cmd_valid_d = 1'b1;
      wd_cnt_d    = '0;
    end else if (wd_cnt_q == WD_LAST) begin
      if (drive_on) begin
        fblr_d    = '0;
        timeout_d = 1'b1;
        wd_cnt_d  = '0;
      end
    end else begin
      wd_cnt_d = wd_cnt_q + 1'b1;
    end
  end

  // Output registers and watchdog counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      {F, B, L, R} <= '0;
      cmd_valid    <= 1'b0;
      timeout      <= 1'b0;
      wd_cnt_q     <= '0;
    end else begin
      {F, B, L, R} <= fblr_d;
      cmd_valid    <= cmd_valid_d;
      timeout      <= timeout_d;
      wd_cnt_q     <= wd_cnt_d;
    end
  end

endmodule

// File: tb/tb_motor_cmd_rx.sv
// Directed bench for motor_cmd_rx: frame-level model with per-cycle compare
// plus literal checks on latency, pulse counts and held outputs.
module tb_motor_cmd_rx;

  localparam int CPB = 10;
  localparam int TMO = 1000;
  // start edge -> outputs: 2 sync + 1 detect + half bit + 8 data + stop + 1 output reg
  localparam int LAT = 4 + CPB / 2 + 9 * CPB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  logic F, B, L, R, cmd_valid, frame_err, timeout;

  motor_cmd_rx #(
    .CLKS_PER_BIT(CPB),
    .TIMEOUT_CLKS(TMO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .F        (F),
    .B        (B),
    .L        (L),
    .R        (R),
    .cmd_valid(cmd_valid),
    .frame_err(frame_err),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  logic rst_q = 1'b0;

  // Edge counter and the reset value seen by each edge.
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int         at;
    logic [7:0] data;
    bit         err;
  } ev_t;

  ev_t evq[$];

  // Spec-level command table: fold lowercase to uppercase, then look up.
  function automatic bit cmd_lookup(input logic [7:0] b, output logic [3:0] fblr);
    logic [7:0] u;
    u = (b >= 8'h61 && b <= 8'h7A) ? b - 8'h20 : b;
    fblr = 4'b0000;
    case (u)
      8'h46: begin fblr = 4'b1000; return 1'b1; end
      8'h42: begin fblr = 4'b0100; return 1'b1; end
      8'h4C: begin fblr = 4'b0010; return 1'b1; end
      8'h52: begin fblr = 4'b0001; return 1'b1; end
      8'h53: begin fblr = 4'b0000; return 1'b1; end
      default: return 1'b0;
    endcase
  endfunction

  logic [3:0] m_fblr = 4'b0000;
  logic [3:0] m_bits;
  logic       ecv, efe, eto, hit;
  int         m_ref = 0;
  bit         armed = 1'b0;
  ev_t        ev;

  int         cv_cnt = 0, to_cnt = 0, fe_cnt = 0;
  int         last_cv_cyc = 0, last_to_cyc = 0;
  logic [3:0] last_cv_fblr = 4'b0000;

  // Model update and compare of every output on every cycle after reset.
  always @(negedge clk) begin
    ecv = 1'b0; efe = 1'b0; eto = 1'b0; hit = 1'b0;
    if (rst_q) begin
      armed  = 1'b1;
      m_fblr = 4'b0000;
      evq.delete();
    end else if (armed) begin
      while (evq.size() > 0 && evq[0].at <= cyc) begin
        ev = evq.pop_front();
        if (ev.at == cyc) begin
          if (ev.err) begin
            efe = 1'b1;
          end else if (cmd_lookup(ev.data, m_bits)) begin
            m_fblr = m_bits;
            ecv    = 1'b1;
            m_ref  = cyc;
            hit    = 1'b1;
          end
        end
      end
      if (!hit && m_fblr != 4'b0000 && (cyc - m_ref) == TMO) begin
        m_fblr = 4'b0000;
        eto    = 1'b1;
      end
    end
    if (armed) begin
      check("model_cmp", {25'd0, F, B, L, R, cmd_valid, frame_err, timeout},
            {25'd0, m_fblr, ecv, efe, eto});
      if (cmd_valid === 1'b1) begin
        cv_cnt++;
        last_cv_cyc  = cyc;
        last_cv_fblr = {F, B, L, R};
      end
      if (timeout === 1'b1) begin
        to_cnt++;
        last_to_cyc = cyc;
      end
      if (frame_err === 1'b1) fe_cnt++;
    end
  end

  // All driver tasks start and end 1 time unit after a rising edge.
  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    hold(1'b1, n);
  endtask

  task automatic send(input logic [7:0] d, input logic stop, input int stop_len,
                      input int rst_bit, output int k0);
    k0 = cyc;
    if (stop) evq.push_back('{k0 + LAT, d, 1'b0});
    else      evq.push_back('{k0 + LAT - 1, d, 1'b1});
    hold(1'b0, CPB);
    for (int i = 0; i < 8; i++) begin
      if (i == rst_bit) rst = 1'b1;
      hold(d[i], CPB);
    end
    hold(stop, stop_len);
    rst = 1'b0;
  endtask

  task automatic send_ok(input logic [7:0] d, output int k0);
    send(d, 1'b1, CPB, -1, k0);
  endtask

  int k, k2, n0, n1, n2;

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_fblr", {28'd0, F, B, L, R}, 32'd0);
    check("reset_pulses", {29'd0, cmd_valid, frame_err, timeout}, 32'd0);
    rst = 1'b0;
    idle(5);

    // Forward, then lowercase left back-to-back
    send_ok(8'h46, k);
    check("f_latency", last_cv_cyc - k, 32'd99);
    check("f_out", {28'd0, last_cv_fblr}, 32'b1000);
    send_ok(8'h6C, k);
    check("l_latency", last_cv_cyc - k, 32'd99);
    check("l_out", {28'd0, F, B, L, R}, 32'b0010);
    idle(20);

    // Unrecognised byte between commands
    n0 = cv_cnt;
    send_ok(8'h42, k);
    send_ok(8'h41, k);
    idle(3);
    check("a_no_cmd_valid", cv_cnt - n0, 32'd1);
    check("b_held", {28'd0, F, B, L, R}, 32'b0100);
    send_ok(8'h53, k);
    check("stop_out", {28'd0, F, B, L, R}, 32'b0000);
    idle(20);

    // Watchdog expiry and no repeat while stopped
    n0 = to_cnt;
    send_ok(8'h52, k);
    check("r_out", {28'd0, F, B, L, R}, 32'b0001);
    idle(1100);
    check("to_once", to_cnt - n0, 32'd1);
    check("to_delay", last_to_cyc - last_cv_cyc, 32'd1000);
    check("to_cleared", {28'd0, F, B, L, R}, 32'b0000);
    n1 = to_cnt;
    idle(1000);
    check("to_no_repeat", to_cnt - n1, 32'd0);

    // Command landing on the expiry cycle wins
    send_ok(8'h52, k);
    n0 = to_cnt;
    repeat ((k + TMO) - cyc) @(posedge clk);
    #1;
    send_ok(8'h72, k2);
    check("collision_cmd_cycle", last_cv_cyc - (k + LAT), 32'd1000);
    check("collision_no_to", to_cnt - n0, 32'd0);
    check("collision_r_held", {28'd0, F, B, L, R}, 32'b0001);
    send_ok(8'h73, k);
    idle(10);

    // Bad stop bit held low, then recovery
    send_ok(8'h4C, k);
    n0 = fe_cnt;
    n1 = cv_cnt;
    send(8'h46, 1'b0, 50, -1, k);
    idle(5);
    check("fe_once", fe_cnt - n0, 32'd1);
    check("fe_no_cmd", cv_cnt - n1, 32'd0);
    check("fe_l_held", {28'd0, F, B, L, R}, 32'b0010);
    send_ok(8'h46, k);
    check("fe_recover_f", {28'd0, F, B, L, R}, 32'b1000);
    check("fe_recover_cv", cv_cnt - n1, 32'd1);
    idle(10);

    // Repeated command, then reset mid-frame
    n0 = cv_cnt;
    send_ok(8'h46, k);
    check("repeat_cv", cv_cnt - n0, 32'd1);
    check("repeat_f", {28'd0, F, B, L, R}, 32'b1000);
    n0 = cv_cnt;
    send(8'h42, 1'b1, CPB, 4, k);
    idle(20);
    check("rst_cleared", {28'd0, F, B, L, R}, 32'b0000);
    check("rst_no_decode", cv_cnt - n0, 32'd0);

    // Single-cycle glitch
    n0 = cv_cnt; n1 = fe_cnt; n2 = to_cnt;
    rx = 1'b0;
    @(posedge clk);
    #1;
    idle(40);
    check("glitch_cv", cv_cnt - n0, 32'd0);
    check("glitch_fe", fe_cnt - n1, 32'd0);
    check("glitch_to", to_cnt - n2, 32'd0);
    send_ok(8'h62, k);
    check("post_glitch_b", {28'd0, F, B, L, R}, 32'b0100);
    idle(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Hard stop if the run never reaches the summary.
  initial begin
    #2000000;
    $display("FAIL sim_time_limit: got expired expected summary before limit");
    $fatal(1, "time limit");
  end

endmodule
